// File: rtl/apb_slv_mem_regfile.sv
// Purpose: APB slave fronting a word-addressed register-file memory with byte-strobed writes.
// Latency: 2 cycles per transfer (setup + access); 3 with APB_WAIT_STATE_EN (one wait state).
// Backpressure: PREADY is registered; outside a transfer it is 0, and PSEL=0 mid-transfer aborts.
//
// Compile-time option: APB_WAIT_STATE_EN inserts one wait state between setup and access.
//
// Ports:
//   PCLK     in   bus clock, all logic on the rising edge
//   PRESETn  in   synchronous reset, ACTIVE HIGH (1 = reset) despite the suffix
//   PADDR    in   word index (not a byte address)
//   PSEL     in   slave select
//   PENABLE  in   access-phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PWDATA   in   write data
//   PSTROBE  in   byte write enables, bit i covers PWDATA[8i+7:8i]
//   PREADY   out  transfer completes when PSEL & PENABLE & PREADY
//   PRDATA   out  read data, zero unless PREADY=1 on a valid read
//   PSLVERR  out  error response for PADDR >= MEM_DEPTH, valid with PREADY
module apb_slv_mem_regfile #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 5,
  parameter int MEM_DEPTH = 24
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [ADDR_SIZE-1:0]   PADDR,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [DATA_SIZE-1:0]   PWDATA,
  input  logic [DATA_SIZE/8-1:0] PSTROBE,
  output logic                   PREADY,
  output logic [DATA_SIZE-1:0]   PRDATA,
  output logic                   PSLVERR
);

  localparam int NBYTES = DATA_SIZE / 8;
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // Depth expressed one bit wider than PADDR so MEM_DEPTH == 2**ADDR_SIZE still fits.
  localparam logic [ADDR_SIZE:0] DEPTH_LIM = (ADDR_SIZE + 1)'(MEM_DEPTH);

`ifdef APB_WAIT_STATE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_WAIT} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;
`endif

  state_t state_q;
  state_t state_d;
  state_t phase;

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  logic                 addr_ok;
  logic [IDX_W-1:0]     idx;
  logic [DATA_SIZE-1:0] rd_word;
  logic                 load_resp;
  logic                 mem_we;
  logic                 pready_d;
  logic                 pslverr_d;
  logic [DATA_SIZE-1:0] prdata_d;

  // ---------------------------------------------------------------------------
  // Address decode and read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_ok = ({1'b0, PADDR} < DEPTH_LIM);
    idx     = PADDR[IDX_W-1:0];
    rd_word = '0;
    if (addr_ok) begin
      rd_word = mem[idx];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and response decode
  //
  // SETUP is decoded from the bus rather than stored: the cycle in which the
  // master presents PSEL=1, PENABLE=0 is the setup cycle, and its closing edge
  // must already load PREADY/PRDATA/PSLVERR so that the registered response is
  // visible in the very next (access) cycle. A new setup seen while a transfer
  // is pending also lands here, which abandons the old transfer without a
  // write and serves the new one.
  // ---------------------------------------------------------------------------
  always_comb begin
    phase     = state_q;
    state_d   = ST_IDLE;
    load_resp = 1'b0;
    mem_we    = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;

    if (PSEL && !PENABLE) begin
      phase = ST_SETUP;
    end

    case (phase)
      ST_SETUP: begin
`ifdef APB_WAIT_STATE_EN
        state_d = ST_WAIT;
`else
        state_d   = ST_ACCESS;
        load_resp = 1'b1;
`endif
      end

`ifdef APB_WAIT_STATE_EN
      ST_WAIT: begin
        // First access-phase cycle is held with PREADY=0; the response is
        // loaded at its closing edge. PSEL low falls through to IDLE.
        if (PSEL && PENABLE) begin
          state_d   = ST_ACCESS;
          load_resp = 1'b1;
        end
      end
`endif

      ST_ACCESS: begin
        // PREADY is 1 throughout ACCESS, so PSEL&PENABLE alone completes.
        // Completion and abort both return to IDLE with outputs cleared.
        if (PSEL && PENABLE) begin
          mem_we = PWRITE && addr_ok;
        end
      end

      default: begin
        // IDLE, including PSEL&PENABLE with no preceding setup: ignored.
      end
    endcase

    if (load_resp) begin
      pready_d  = 1'b1;
      pslverr_d = !addr_ok;
      prdata_d  = PWRITE ? '0 : rd_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else begin
      PREADY  <= pready_d;
      PRDATA  <= prdata_d;
      PSLVERR <= pslverr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory: cleared by reset, byte-strobed write at the completing edge.
  // Reset has priority, so a reset in the access phase suppresses the write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (PSTROBE[b]) begin
          mem[idx][8*b +: 8] <= PWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_slv_mem_regfile.sv
module tb_apb_slv_mem_regfile;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 24;
`ifdef APB_WAIT_STATE_EN
  localparam int WS = 1;
`else
  localparam int WS = 0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [3:0]    PSTROBE;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;

  apb_slv_mem_regfile #(
    .DATA_SIZE(DW),
    .ADDR_SIZE(AW),
    .MEM_DEPTH(DEPTH)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PADDR  (PADDR),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PWDATA (PWDATA),
    .PSTROBE(PSTROBE),
    .PREADY (PREADY),
    .PRDATA (PRDATA),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Behavioural model: memory contents plus the response the bus should see
  // in the current cycle, filled in by the transaction tasks.
  logic [DW-1:0] model_mem [DEPTH];
  logic          exp_ready;
  logic          exp_err;
  logic [DW-1:0] exp_rdata;
  bit            chk_en = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] rd;
  logic          er;
  logic          ry;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_exp(input logic r, input logic [DW-1:0] d, input logic e);
    exp_ready = r;
    exp_rdata = d;
    exp_err   = e;
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic go_idle();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    set_exp(1'b0, '0, 1'b0);
  endtask

  task automatic idle(input int n);
    go_idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  // Per-cycle compare against the model.
  always @(negedge PCLK) begin
    if (chk_en) begin
      chk("cyc_pready",  {31'b0, PREADY},  {31'b0, exp_ready});
      chk("cyc_pslverr", {31'b0, PSLVERR}, {31'b0, exp_err});
      chk("cyc_prdata",  PRDATA,           exp_rdata);
    end
  end

  // One APB transfer starting at a posedge+1 boundary.
  // mode 0: normal; 1: PSEL dropped in the first access cycle;
  // 2: reset asserted in the completing access cycle.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [3:0] strb, input int mode,
                      output logic [DW-1:0] rdata, output logic err, output logic rdy);
    logic          valid;
    logic [DW-1:0] resp;
    valid = int'(addr) < DEPTH;
    resp  = (!wr && valid) ? model_mem[addr] : '0;

    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata; PSTROBE = strb;
    set_exp(1'b0, '0, 1'b0);
    tick();

    PENABLE = 1'b1;
    if (mode == 1) begin
      PSEL = 1'b0; PENABLE = 1'b0;
      if (WS == 0) set_exp(1'b1, resp, !valid);
      else         set_exp(1'b0, '0, 1'b0);
      @(negedge PCLK);
      rdata = PRDATA; err = PSLVERR; rdy = PREADY;
      tick();
      set_exp(1'b0, '0, 1'b0);
      return;
    end

    for (int w = 0; w < WS; w++) begin
      set_exp(1'b0, '0, 1'b0);
      tick();
    end

    if (mode == 2) PRESETn = 1'b1;
    set_exp(1'b1, resp, !valid);
    @(negedge PCLK);
    rdata = PRDATA; err = PSLVERR; rdy = PREADY;
    tick();
    set_exp(1'b0, '0, 1'b0);

    if (mode == 2) begin
      PRESETn = 1'b0;
      model_clear();
    end else if (wr && valid) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_mem[addr][8*b +: 8] = wdata[8*b +: 8];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PADDR = '0; PWRITE = 1'b0;
    PWDATA = '0; PSTROBE = '0;
    set_exp(1'b0, '0, 1'b0);
    model_clear();

    // Two reset cycles; outputs defined after the first reset edge.
    tick();
    chk_en = 1'b1;
    tick();
    PRESETn = 1'b0;
    @(negedge PCLK);
    chk("rst_pready",  {31'b0, PREADY},  32'h0);
    chk("rst_prdata",  PRDATA,           32'h0);
    chk("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    tick();

    xfer(1'b0, 5'd3, '0, 4'h0, 0, rd, er, ry);
    chk("rst_rd3_data",  rd,            32'h0000_0000);
    chk("rst_rd3_err",   {31'b0, er},   32'h0);
    chk("rst_rd3_ready", {31'b0, ry},   32'h1);
    idle(1);

    // Full write / read.
    xfer(1'b1, 5'd5, 32'hDEAD_BEEF, 4'hF, 0, rd, er, ry);
    chk("wr5_ready", {31'b0, ry}, 32'h1);
    chk("wr5_data",  rd,          32'h0);
    idle(1);
    xfer(1'b0, 5'd5, '0, 4'h0, 0, rd, er, ry);
    chk("rd5_full", rd,          32'hDEAD_BEEF);
    chk("rd5_err",  {31'b0, er}, 32'h0);
    idle(1);

    // Byte strobes, then an all-zero strobe write that changes nothing.
    xfer(1'b1, 5'd5, 32'h1122_3344, 4'b0101, 0, rd, er, ry);
    idle(1);
    xfer(1'b0, 5'd5, '0, 4'h0, 0, rd, er, ry);
    chk("rd5_strobe", rd, 32'hDE22_BE44);
    idle(1);
    xfer(1'b1, 5'd5, 32'hCAFE_F00D, 4'b0000, 0, rd, er, ry);
    chk("wr5_nostrb_err", {31'b0, er}, 32'h0);
    idle(1);
    xfer(1'b0, 5'd5, '0, 4'h0, 0, rd, er, ry);
    chk("rd5_nostrb", rd, 32'hDE22_BE44);
    idle(1);

    // Error decode at and beyond the depth boundary.
    xfer(1'b1, 5'd23, 32'h0BAD_F00D, 4'hF, 0, rd, er, ry);
    idle(1);
    xfer(1'b1, 5'd24, 32'hFFFF_FFFF, 4'hF, 0, rd, er, ry);
    chk("wr24_err",   {31'b0, er}, 32'h1);
    chk("wr24_ready", {31'b0, ry}, 32'h1);
    idle(1);
    xfer(1'b0, 5'd24, '0, 4'h0, 0, rd, er, ry);
    chk("rd24_err",  {31'b0, er}, 32'h1);
    chk("rd24_data", rd,          32'h0);
    idle(1);
    xfer(1'b0, 5'd23, '0, 4'h0, 0, rd, er, ry);
    chk("rd23_data", rd,          32'h0BAD_F00D);
    chk("rd23_err",  {31'b0, er}, 32'h0);
    idle(1);
    xfer(1'b0, 5'd31, '0, 4'h0, 0, rd, er, ry);
    chk("rd31_err", {31'b0, er}, 32'h1);
    idle(2);

    // Back-to-back write then read of the same word.
    xfer(1'b1, 5'd0, 32'hA5A5_A5A5, 4'hF, 0, rd, er, ry);
    xfer(1'b0, 5'd0, '0, 4'h0, 0, rd, er, ry);
    chk("b2b_rd0", rd, 32'hA5A5_A5A5);
    idle(1);

    // Abort: PSEL dropped in the access phase of a write.
    xfer(1'b1, 5'd1, 32'h1234_5678, 4'hF, 1, rd, er, ry);
    go_idle();
    @(negedge PCLK);
    chk("abort_pready_after", {31'b0, PREADY}, 32'h0);
    tick();
    xfer(1'b0, 5'd1, '0, 4'h0, 0, rd, er, ry);
    chk("abort_rd1", rd, 32'h0);
    idle(1);

    // Reset during the access phase of a write.
    xfer(1'b1, 5'd2, 32'h7777_7777, 4'hF, 2, rd, er, ry);
    idle(1);
    xfer(1'b0, 5'd2, '0, 4'h0, 0, rd, er, ry);
    chk("midrst_rd2", rd, 32'h0);
    idle(1);
    xfer(1'b0, 5'd5, '0, 4'h0, 0, rd, er, ry);
    chk("midrst_rd5_cleared", rd, 32'h0);
    idle(1);

    // Protocol violation: access phase with no setup.
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 5'd6;
    PWDATA = 32'hFFFF_FFFF; PSTROBE = 4'hF;
    set_exp(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("viol_pready", {31'b0, PREADY}, 32'h0);
      tick();
    end
    idle(1);
    xfer(1'b0, 5'd6, '0, 4'h0, 0, rd, er, ry);
    chk("viol_rd6", rd, 32'h0);
    idle(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
